// File: rtl/shift_seq_pkg.sv
// Shared state encoding and shifter mode-select constants for the shift sequencer.
package shift_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [1:0] SEL_LOAD = 2'b00;
  localparam logic [1:0] SEL_SHR3 = 2'b01;
  localparam logic [1:0] SEL_SHR2 = 2'b10;
  localparam logic [1:0] SEL_SHR1 = 2'b11;

endpackage

// File: rtl/shr8_dp.sv
// 8-bit mode-select shifter: load, or logical right shift by 3/2/1 with zero fill.
// One op per cycle, result registered; no hold mode, so callers reload out to hold.
module shr8_dp
  import shift_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] sel,
  input  logic [7:0] din,
  output logic [7:0] dout
);

  always_ff @(posedge clk) begin
    if (rst) begin
      dout <= 8'h00;
    end else begin
      case (sel)
        SEL_LOAD: dout <= din;
        SEL_SHR3: dout <= dout >> 3;
        SEL_SHR2: dout <= dout >> 2;
        default:  dout <= dout >> 1;
      endcase
    end
  end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Loads one command into the shifter, then issues the greedy >>3/>>2/>>1 sequence; done pulses one cycle.
// Latency: done in the cycle after E(1+ceil(amt/3)); start outside IDLE is dropped, never queued.
module shift_seq_ctrl
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  input  logic [AMT_W-1:0] amt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dout,
  output logic [1:0]       sel,
  output logic [2:0]       steps
);

  localparam logic [AMT_W-1:0] AMT_MAX = AMT_W'(WIDTH);
  localparam logic [AMT_W-1:0] THREE   = AMT_W'(3);

  state_t           state, state_n;
  logic [WIDTH-1:0] din_q;
  logic [AMT_W-1:0] rem;
  logic [AMT_W-1:0] amt_clamped;
  logic [WIDTH-1:0] dp_in;

  assign amt_clamped = (amt > AMT_MAX) ? AMT_MAX : amt;

  // sel is decoded from state/rem only, so start never reaches the outputs combinationally.
  always_comb begin
    state_n = state;
    sel     = SEL_LOAD;
    dp_in   = dout;
    case (state)
      IDLE: begin
        if (start) state_n = LOAD;
      end
      LOAD: begin
        dp_in   = din_q;
        state_n = (rem != '0) ? SHIFT : DONE;
      end
      SHIFT: begin
        if (rem >= THREE)              sel = SEL_SHR3;
        else if (rem == AMT_W'(2))     sel = SEL_SHR2;
        else                           sel = SEL_SHR1;
        state_n = (rem > THREE) ? SHIFT : DONE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      din_q <= '0;
      rem   <= '0;
      steps <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && start) begin
        din_q <= din;
        rem   <= amt_clamped;
        steps <= '0;
      end else if (state == SHIFT) begin
        rem   <= (rem >= THREE) ? rem - THREE : '0;
        steps <= steps + 3'd1;
      end
    end
  end

  assign busy = (state == LOAD) || (state == SHIFT);
  assign done = (state == DONE);

  shr8_dp u_dp (
    .clk  (clk),
    .rst  (rst),
    .sel  (sel),
    .din  (dp_in),
    .dout (dout)
  );

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl: hand-computed sel sequences, results, step counts and timing.
module tb_shift_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] din;
  logic [3:0] amt;
  logic       busy;
  logic       done;
  logic [7:0] dout;
  logic [1:0] sel;
  logic [2:0] steps;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  shift_seq_ctrl #(.WIDTH(8), .AMT_W(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .din   (din),
    .amt   (amt),
    .busy  (busy),
    .done  (done),
    .dout  (dout),
    .sel   (sel),
    .steps (steps)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ops lists the expected shift modes first-op-first in the top bits.
  task automatic cmd(input string tag, input logic [7:0] d, input logic [3:0] a,
                     input int n, input logic [5:0] ops, input logic [7:0] exp_d);
    din = d; amt = a; start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_load_busy"}, 8'(busy), 8'h01);
    chk({tag, "_load_sel"},  8'(sel),  8'h00);
    chk({tag, "_load_done"}, 8'(done), 8'h00);
    for (int i = 0; i < n; i++) begin
      tick();
      chk({tag, "_shift_busy"}, 8'(busy), 8'h01);
      chk({tag, "_shift_sel"},  8'(sel),  8'(ops[5-2*i -: 2]));
      chk({tag, "_shift_done"}, 8'(done), 8'h00);
    end
    tick();
    chk({tag, "_done"},       8'(done),  8'h01);
    chk({tag, "_done_busy"},  8'(busy),  8'h00);
    chk({tag, "_dout"},       dout,      exp_d);
    chk({tag, "_steps"},      8'(steps), 8'(n));
    chk({tag, "_done_sel"},   8'(sel),   8'h00);
    tick();
    chk({tag, "_idle_done"},  8'(done),  8'h00);
    chk({tag, "_idle_dout"},  dout,      exp_d);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; din = 8'h00; amt = 4'd0;

    // T1 reset
    tick(); tick();
    chk("rst_dout",  dout,      8'h00);
    chk("rst_busy",  8'(busy),  8'h00);
    chk("rst_done",  8'(done),  8'h00);
    chk("rst_steps", 8'(steps), 8'h00);
    chk("rst_sel",   8'(sel),   8'h00);
    rst = 1'b0;
    tick();

    // T2..T4 directed commands
    cmd("t2_b5_5",  8'hB5, 4'd5,  2, 6'b01_10_00, 8'h05);
    cmd("t3_a5_0",  8'hA5, 4'd0,  0, 6'b00_00_00, 8'hA5);
    cmd("t3_ff_13", 8'hFF, 4'd13, 3, 6'b01_01_10, 8'h00);
    cmd("t4_80_7",  8'h80, 4'd7,  3, 6'b01_01_11, 8'h01);

    // T5 start held through LOAD/SHIFT/DONE with a different command: F0>>4 = 0F
    din = 8'hF0; amt = 4'd4; start = 1'b1;
    tick();
    din = 8'h00; amt = 4'd0;
    chk("t5_load_busy", 8'(busy), 8'h01);
    tick();
    chk("t5_s1_sel", 8'(sel), 8'h01);
    tick();
    chk("t5_s2_sel", 8'(sel), 8'h03);
    tick();
    chk("t5_done",  8'(done),  8'h01);
    chk("t5_dout",  dout,      8'h0F);
    chk("t5_steps", 8'(steps), 8'h02);
    tick();
    start = 1'b0;
    chk("t5_idle_busy", 8'(busy), 8'h00);
    chk("t5_idle_done", 8'(done), 8'h00);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t5_hold_dout", dout,      8'h0F);
      chk("t5_hold_busy", 8'(busy),  8'h00);
      chk("t5_hold_done", 8'(done),  8'h00);
      chk("t5_hold_steps", 8'(steps), 8'h02);
    end

    // T6 reset during the second SHIFT of amt=8
    din = 8'hFF; amt = 4'd8; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("t6_s1_sel", 8'(sel), 8'h01);
    tick();
    chk("t6_s2_sel",  8'(sel), 8'h01);
    chk("t6_s2_dout", dout,    8'h1F);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_rst_dout",  dout,      8'h00);
    chk("t6_rst_busy",  8'(busy),  8'h00);
    chk("t6_rst_done",  8'(done),  8'h00);
    chk("t6_rst_steps", 8'(steps), 8'h00);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t6_no_done", 8'(done), 8'h00);
      chk("t6_no_busy", 8'(busy), 8'h00);
    end
    cmd("t6_3c_2", 8'h3C, 4'd2, 1, 6'b10_00_00, 8'h0F);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
